// File: rtl/array_26_pkg.sv
// Shared constants and types for the array_26 request front-end.
// Optional build macro: ARRAY_26_CTRL_INIT_EN (zero-fill sweep after reset).
package array_26_pkg;

    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned LANES     = 16;
    localparam int unsigned LANE_W    = 7;
    localparam int unsigned DATA_W    = LANES * LANE_W;
    localparam int unsigned DEPTH     = 4096;
    localparam int unsigned RSP_DEPTH = 2;
    localparam int unsigned CNT_W     = $clog2(RSP_DEPTH + 1);

    typedef enum logic {
        StInit,
        StRun
    } init_state_e;

endpackage

// File: rtl/array_26_rsp_q.sv
// Small FIFO holding read responses so macro read data never has to be held.
module array_26_rsp_q #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 112,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             valid,
    output logic [CntW-1:0]  count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CntW'(Depth)) || do_pop);

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are meaningless while the slot is empty
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign valid = (count_q != '0);
    assign count = count_q;

endmodule

// File: rtl/array_26_ctrl.sv
// Request front-end for the 4096 x 112-bit lane-masked single-port array macro.
// Optional build macro: ARRAY_26_CTRL_INIT_EN adds a zero-fill sweep after reset.
module array_26_ctrl
    import array_26_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LANES-1:0]  req_mask,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              init_done,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LANES-1:0]  mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              rd_pending_q;
    logic              init_done_q, init_done_d;
    logic              fire, pop, q_valid;
    logic [CNT_W-1:0]  q_count;
    logic [CNT_W:0]    used;
    logic              sweeping;
    logic [ADDR_W-1:0] sweep_addr;

`ifdef ARRAY_26_CTRL_INIT_EN
    init_state_e       state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;

    // Sweep one address per cycle, leave INIT after the last one is written
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == StInit) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == ADDR_W'(DEPTH - 1)) begin
                state_d = StRun;
            end
        end
    end

    // Init FSM state; reset restarts the sweep at address 0
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StInit;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    assign sweeping    = reset && (state_q == StInit);
    assign sweep_addr  = sweep_q;
    assign init_done_d = (state_d == StRun);
`else
    assign sweeping    = 1'b0;
    assign sweep_addr  = '0;
    assign init_done_d = 1'b1;
`endif

    // Outputs are forced idle while reset is low, even before the reset edge
    assign init_done = reset && init_done_q;
    assign rsp_valid = reset && q_valid;
    assign pop       = rsp_valid && rsp_ready;

    // Credits: queued + in-flight reads, minus the one leaving this cycle
    assign used      = {1'b0, q_count} + (CNT_W + 1)'(rd_pending_q) - (CNT_W + 1)'(pop);
    assign req_ready = init_done && (used < (CNT_W + 1)'(RSP_DEPTH));
    assign fire      = req_valid && req_ready;

    // Macro port drive: sweep during init, otherwise the accepted request
    always_comb begin
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        if (sweeping) begin
            mem_en    = 1'b1;
            mem_wmode = 1'b1;
            mem_addr  = sweep_addr;
            mem_wmask = '1;
        end else if (fire) begin
            mem_en    = 1'b1;
            mem_wmode = req_write;
            mem_addr  = req_addr;
            mem_wmask = req_write ? req_mask : '0;
            mem_wdata = req_data;
        end
    end

    // Read-in-flight flag and init_done register
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_pending_q <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            rd_pending_q <= fire && !req_write;
            init_done_q  <= init_done_d;
        end
    end

    array_26_rsp_q #(
        .Depth (RSP_DEPTH),
        .Width (DATA_W),
        .CntW  (CNT_W)
    ) u_rsp_q (
        .clock (clock),
        .reset (reset),
        .push  (rd_pending_q),
        .wdata (mem_rdata),
        .pop   (pop),
        .rdata (rsp_data),
        .valid (q_valid),
        .count (q_count)
    );

endmodule
